rx_frame_demux: RTL and testbench
=================================

Name: rx_frame_demux

Overview:
- Receive-side successor to the single-channel RX FSM. Sits between the router RX AXI-Stream and the transport layer.
- Consumes the first beat of each frame as a MAC header, filters on destination MAC and an upstream error flag, and strips the header.
- Forwards payload beats to one of NUM_CHANNELS transport channels selected by a header field. Frames that fail filtering are sunk, and the drops are counted.

Parameters:
- DATA_WIDTH, 16, stream width in bytes (minimum 14, must hold the MAC header plus the channel field).
- NUM_CHANNELS, 4, number of downstream transport channels (1..16).
- CHAN_FIELD_LSB, 96, bit offset of the channel-index field in the header beat; field width is CW = max(1, clog2(NUM_CHANNELS)).
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- user_clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- s_axis_tdata  in  DATA_WIDTH*8  router data.
- s_axis_tkeep  in  DATA_WIDTH  router byte enables.
- s_axis_tvalid  in  1  router valid.
- s_axis_tlast  in  1  router end of frame.
- s_axis_tuser  in  4  router sideband; bit2 = upstream error.
- s_axis_tready  out  1  ready to router.
- m_axis_tdata  out  DATA_WIDTH*8  payload, shared by all channels.
- m_axis_tkeep  out  DATA_WIDTH  shared byte enables.
- m_axis_tlast  out  1  shared end of frame.
- m_axis_tuser  out  4  frame tuser latched from the header beat.
- m_axis_tvalid  out  NUM_CHANNELS  per-channel valid, at most one bit set.
- m_axis_tready  in  NUM_CHANNELS  per-channel ready.
- local_mac_addr  in  48  station MAC address.
- rx_dst_mac_addr  out  48  dst MAC of the last header, registered.
- rx_chan  out  CW  channel index of the current or last frame.
- frame_cnt  out  CNT_WIDTH  frames accepted.
- drop_cnt  out  CNT_WIDTH  frames dropped.

Behaviour:
- Header beat layout: dst MAC = tdata[95:48]; src MAC = tdata[47:0]; channel index = tdata[CHAN_FIELD_LSB +: CW].
- Reset values (asynchronous, reset_n=0): state HEADER; all m_axis_tvalid=0; m_axis data/keep/last/user=0; rx_dst_mac_addr=0; rx_chan=0; frame_cnt=0; drop_cnt=0. s_axis_tready=1 after reset is released.
- Reset asserted mid-frame: any partial frame is abandoned. After release, the next beat is treated as a header.
- State HEADER:
  - s_axis_tready=1. On handshake, latch dst MAC, channel index and tuser.
  - Accept condition: dst==local_mac_addr AND tuser[2]==0 AND index<NUM_CHANNELS AND tlast==0.
  - Accept -> FWD, and frame_cnt increments.
  - Otherwise -> DROP (or stays HEADER if the header beat has tlast=1), and drop_cnt increments.
- State FWD:
  - Uses a one-entry output register (skid-free pipeline slot). s_axis_tready = !out_valid | m_axis_tready[rx_chan].
  - On an input handshake, the beat is loaded into the slot and m_axis_tvalid[rx_chan] rises the next cycle. Latency is 1 cycle, and full throughput is sustained when m_axis_tready stays high.
  - Output holds stable while valid and not ready.
  - On a handshake of the tlast beat -> HEADER. The slot may still hold that beat, and it drains while the next header is consumed; header beats never enter the slot.
  - Frame-level tuser (tuser latched from the header) is presented unchanged on every beat.
- State DROP: s_axis_tready=1; beats are discarded; a tlast handshake -> HEADER.
- Counters saturate at all-ones and do not wrap.
- A frame is counted exactly once, at its header.
- Combinational outputs: none except s_axis_tready.

Optional Feature:
- Macro RX_BCAST_ACCEPT_EN.
- Defined: a dst MAC of 48'hFFFF_FFFF_FFFF also passes the MAC check; the frame is forwarded to the channel selected by the index field as normal.
- Undefined: broadcast frames are dropped and counted in drop_cnt.

Decomposition:
- Shared package rx_pkg:
  - header field offsets: DST_MAC_MSB=95, DST_MAC_LSB=48, SRC_MAC_MSB=47;
  - TUSER_ERR_BIT=2;
  - BCAST_MAC constant;
  - state encoding typedef {HEADER, FWD, DROP}.
- One natural sub-module: rx_out_slot, the one-entry valid/ready register holding data/keep/last/user with channel-indexed valid fan-out.

Test Plan:
- Matching frame, local_mac_addr=48'h0A0B0C0D0E0F, channel field=2, 3 payload beats, all ready -> only m_axis_tvalid[2] pulses 3 cycles starting 1 cycle after each input beat, header stripped, frame_cnt=1.
- dst MAC 48'h112233445566 (mismatch), 4 beats -> no m_axis_tvalid, s_axis_tready held 1, drop_cnt=1, next matching frame forwards normally.
- Header with tuser=4'b0100 or channel index 5 (NUM_CHANNELS=4) -> frame dropped, drop_cnt increments; single-beat header with tlast=1 -> dropped, FSM stays HEADER.
- Backpressure: m_axis_tready[1] low for 5 cycles mid-frame -> s_axis_tready low, output beat held stable, no beat lost or duplicated, order preserved.
- Back-to-back frames to channels 0 then 3 with no idle -> header of frame 2 consumed while frame 1 last beat drains; tvalid never set on two channels at once.
- Broadcast dst frame -> forwarded with RX_BCAST_ACCEPT_EN defined; dropped with drop_cnt=1 without it. Separate case: assert reset_n=0 mid-frame -> all outputs return to reset values immediately, counters read 0.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared definitions for the RX frame demultiplexer: header field offsets,
// sideband bit positions and the receive state encoding.
package rx_pkg;

  localparam int DST_MAC_MSB   = 95;
  localparam int DST_MAC_LSB   = 48;
  localparam int SRC_MAC_MSB   = 47;
  localparam int TUSER_ERR_BIT = 2;
  // Index range is checked over a 4-bit window (enough for 16 channels), so
  // indices that alias onto a valid channel in CW bits are still rejected.
  localparam int CHAN_CHK_W    = 4;

  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {HEADER, FWD, DROP} rx_state_e;

endpackage

// File: rtl/rx_out_slot.sv
// One-entry valid/ready output register. It remembers the channel each beat
// was loaded for, so a draining beat never follows a newer header's channel.
module rx_out_slot #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CHANNELS = 4,
  parameter int CW           = 2
) (
  input  logic                      user_clk,
  input  logic                      reset_n,
  input  logic                      load,
  input  logic [DATA_WIDTH*8-1:0]   ld_data,
  input  logic [DATA_WIDTH-1:0]     ld_keep,
  input  logic                      ld_last,
  input  logic [3:0]                ld_user,
  input  logic [CW-1:0]             ld_chan,
  output logic                      can_load,
  output logic [DATA_WIDTH*8-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH-1:0]     m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic [3:0]                m_axis_tuser,
  output logic [NUM_CHANNELS-1:0]   m_axis_tvalid,
  input  logic [NUM_CHANNELS-1:0]   m_axis_tready
);

  typedef struct packed {
    logic [DATA_WIDTH*8-1:0] data;
    logic [DATA_WIDTH-1:0]   keep;
    logic                    last;
    logic [3:0]              user;
  } beat_t;

  beat_t                   beat_q;
  logic [NUM_CHANNELS-1:0] vld_q;
  logic [NUM_CHANNELS-1:0] ld_sel;
  logic [CW-1:0]           chan_q;
  logic                    busy;
  logic                    drain;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_sel
    assign ld_sel[c] = (ld_chan == CW'(c));
  end

  assign busy     = |vld_q;
  assign drain    = busy & m_axis_tready[chan_q];
  assign can_load = !busy | m_axis_tready[chan_q];

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= '0;
      chan_q <= '0;
      beat_q <= '0;
    end else if (load) begin
      vld_q  <= ld_sel;
      chan_q <= ld_chan;
      beat_q <= '{data: ld_data, keep: ld_keep, last: ld_last, user: ld_user};
    end else if (drain) begin
      vld_q  <= '0;
    end
  end

  assign m_axis_tvalid = vld_q;
  assign m_axis_tdata  = beat_q.data;
  assign m_axis_tkeep  = beat_q.keep;
  assign m_axis_tlast  = beat_q.last;
  assign m_axis_tuser  = beat_q.user;

endmodule

// File: rtl/rx_frame_demux.sv
// RX frame demux: filters on the header beat, strips it and steers payload to
// one of NUM_CHANNELS outputs. Define RX_BCAST_ACCEPT_EN to accept broadcast dst.
module rx_frame_demux
  import rx_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_CHANNELS   = 4,
  parameter int CHAN_FIELD_LSB = 96,
  parameter int CNT_WIDTH      = 32,
  localparam int CW            = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                     user_clk,
  input  logic                     reset_n,
  input  logic [DATA_WIDTH*8-1:0]  s_axis_tdata,
  input  logic [DATA_WIDTH-1:0]    s_axis_tkeep,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tlast,
  input  logic [3:0]               s_axis_tuser,
  output logic                     s_axis_tready,
  output logic [DATA_WIDTH*8-1:0]  m_axis_tdata,
  output logic [DATA_WIDTH-1:0]    m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic [3:0]               m_axis_tuser,
  output logic [NUM_CHANNELS-1:0]  m_axis_tvalid,
  input  logic [NUM_CHANNELS-1:0]  m_axis_tready,
  input  logic [47:0]              local_mac_addr,
  output logic [47:0]              rx_dst_mac_addr,
  output logic [CW-1:0]            rx_chan,
  output logic [CNT_WIDTH-1:0]     frame_cnt,
  output logic [CNT_WIDTH-1:0]     drop_cnt
);

  localparam logic [CHAN_CHK_W:0] NCH = (CHAN_CHK_W+1)'(NUM_CHANNELS);

  rx_state_e             state_q, state_d;
  logic [47:0]           hdr_dst;
  logic [CHAN_CHK_W-1:0] hdr_idx;
  logic                  mac_ok, hdr_ok;
  logic                  hdr_hs, fwd_hs;
  logic                  slot_can_load;
  logic [3:0]            frame_user_q;

  assign hdr_dst = s_axis_tdata[DST_MAC_MSB:DST_MAC_LSB];
  assign hdr_idx = s_axis_tdata[CHAN_FIELD_LSB +: CHAN_CHK_W];

`ifdef RX_BCAST_ACCEPT_EN
  assign mac_ok = (hdr_dst == local_mac_addr) || (hdr_dst == BCAST_MAC);
`else
  assign mac_ok = (hdr_dst == local_mac_addr);
`endif

  assign hdr_ok = mac_ok && !s_axis_tuser[TUSER_ERR_BIT] &&
                  ({1'b0, hdr_idx} < NCH) && !s_axis_tlast;

  always_comb begin
    state_d       = state_q;
    s_axis_tready = 1'b0;
    hdr_hs        = 1'b0;
    fwd_hs        = 1'b0;
    case (state_q)
      HEADER: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          hdr_hs  = 1'b1;
          state_d = hdr_ok ? FWD : (s_axis_tlast ? HEADER : DROP);
        end
      end
      FWD: begin
        // Ready follows the slot, which may still hold a beat for an older channel.
        s_axis_tready = slot_can_load;
        if (s_axis_tvalid && slot_can_load) begin
          fwd_hs = 1'b1;
          if (s_axis_tlast) state_d = HEADER;
        end
      end
      DROP: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_d = HEADER;
      end
      default: state_d = HEADER;
    endcase
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) state_q <= HEADER;
    else          state_q <= state_d;
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_dst_mac_addr <= '0;
      rx_chan         <= '0;
      frame_user_q    <= '0;
      frame_cnt       <= '0;
      drop_cnt        <= '0;
    end else if (hdr_hs) begin
      rx_dst_mac_addr <= hdr_dst;
      rx_chan         <= hdr_idx[CW-1:0];
      frame_user_q    <= s_axis_tuser;
      if (hdr_ok) begin
        if (frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
      end else begin
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  rx_out_slot #(
    .DATA_WIDTH   (DATA_WIDTH),
    .NUM_CHANNELS (NUM_CHANNELS),
    .CW           (CW)
  ) u_slot (
    .user_clk      (user_clk),
    .reset_n       (reset_n),
    .load          (fwd_hs),
    .ld_data       (s_axis_tdata),
    .ld_keep       (s_axis_tkeep),
    .ld_last       (s_axis_tlast),
    .ld_user       (frame_user_q),
    .ld_chan       (rx_chan),
    .can_load      (slot_can_load),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

endmodule

// File: tb/tb_rx_frame_demux.sv
// Bench for rx_frame_demux: directed cycle table, randomized frames against a
// frame-level scoreboard, broadcast handling and mid-frame reset.
module tb_rx_frame_demux;

  localparam int DW = 16;
  localparam int NC = 4;
  localparam int CW = 2;
  localparam logic [47:0] LMAC = 48'h0A0B0C0D0E0F;
  localparam logic [47:0] MMAC = 48'h112233445566;
  localparam logic [47:0] BMAC = 48'hFFFFFFFFFFFF;
`ifdef RX_BCAST_ACCEPT_EN
  localparam bit BCAST_OK = 1'b1;
`else
  localparam bit BCAST_OK = 1'b0;
`endif

  logic              user_clk = 1'b0;
  logic              reset_n;
  logic [DW*8-1:0]   s_axis_tdata;
  logic [DW-1:0]     s_axis_tkeep;
  logic              s_axis_tvalid;
  logic              s_axis_tlast;
  logic [3:0]        s_axis_tuser;
  logic              s_axis_tready;
  logic [DW*8-1:0]   m_axis_tdata;
  logic [DW-1:0]     m_axis_tkeep;
  logic              m_axis_tlast;
  logic [3:0]        m_axis_tuser;
  logic [NC-1:0]     m_axis_tvalid;
  logic [NC-1:0]     m_axis_tready;
  logic [47:0]       local_mac_addr;
  logic [47:0]       rx_dst_mac_addr;
  logic [CW-1:0]     rx_chan;
  logic [31:0]       frame_cnt;
  logic [31:0]       drop_cnt;

  logic              rand_en = 1'b0;
  logic [NC-1:0]     rnd_ready = '1;
  logic [NC-1:0]     tbl_ready = '1;

  rx_frame_demux dut (
    .user_clk        (user_clk),
    .reset_n         (reset_n),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tkeep    (s_axis_tkeep),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tuser    (s_axis_tuser),
    .s_axis_tready   (s_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tkeep    (m_axis_tkeep),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tuser    (m_axis_tuser),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .local_mac_addr  (local_mac_addr),
    .rx_dst_mac_addr (rx_dst_mac_addr),
    .rx_chan         (rx_chan),
    .frame_cnt       (frame_cnt),
    .drop_cnt        (drop_cnt)
  );

  always #5 user_clk = ~user_clk;
  always @(posedge user_clk) rnd_ready <= 4'($urandom) | 4'($urandom);
  assign m_axis_tready = rand_en ? rnd_ready : tbl_ready;

  int applied = 0, miscompares = 0;
  int mon_applied = 0, mon_miss = 0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic mchk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    mon_applied++;
    if (act !== exp) begin
      mon_miss++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  typedef struct { logic [127:0] d; logic [15:0] k; logic l; logic [3:0] u; logic [1:0] c; } beat_t;
  beat_t       exp_q[$];
  int          mode = 0;            // 0: next beat is a header, 1: forwarding, 2: discarding
  logic [1:0]  cur_c;
  logic [3:0]  cur_u;
  int          m_fcnt = 0, m_dcnt = 0;
  logic [47:0] m_dst = '0;
  logic [1:0]  m_chan = '0;
  logic        prev_hold = 1'b0;
  logic [152:0] prev_out;

  initial begin : monitor
    beat_t       e;
    logic [47:0] dst;
    logic [3:0]  idx;
    bit          ok;
    forever begin
      @(negedge user_clk or negedge reset_n);
      if (!reset_n) begin
        exp_q.delete();
        mode = 0; m_fcnt = 0; m_dcnt = 0; m_dst = '0; m_chan = '0; prev_hold = 1'b0;
      end else begin
        if (prev_hold)
          mchk("hold_stable", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, prev_out);
        if (m_axis_tvalid != '0)
          mchk("onehot_valid", 160'($countones(m_axis_tvalid)), 160'd1);
        if ((m_axis_tvalid & m_axis_tready) != '0) begin
          if (exp_q.size() == 0) begin
            mchk("unexpected_beat", {m_axis_tvalid, m_axis_tdata}, '0);
          end else begin
            e = exp_q.pop_front();
            mchk("out_beat", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser},
                 {4'b0001 << e.c, e.d, e.k, e.l, e.u});
          end
        end
        prev_hold = (m_axis_tvalid != '0) && ((m_axis_tvalid & m_axis_tready) == '0);
        prev_out  = {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
        if (s_axis_tvalid && s_axis_tready) begin
          if (mode == 0) begin
            dst = s_axis_tdata[95:48];
            idx = s_axis_tdata[99:96];
            ok  = (dst == local_mac_addr || (BCAST_OK && dst == BMAC)) &&
                  !s_axis_tuser[2] && (idx < 4'd4) && !s_axis_tlast;
            m_dst = dst; m_chan = idx[1:0];
            if (ok) begin
              m_fcnt++; mode = 1; cur_c = idx[1:0]; cur_u = s_axis_tuser;
            end else begin
              m_dcnt++; mode = s_axis_tlast ? 0 : 2;
            end
          end else if (mode == 1) begin
            exp_q.push_back('{s_axis_tdata, s_axis_tkeep, s_axis_tlast, cur_u, cur_c});
            if (s_axis_tlast) mode = 0;
          end else if (s_axis_tlast) begin
            mode = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [127:0] hdr_beat(input logic [47:0] dst, input logic [3:0] ch,
                                            input logic [27:0] hi, input logic [47:0] src);
    return {hi, ch, dst, src};
  endfunction

  // Called and returns at posedge+1.
  task automatic send_beat(input logic [127:0] d, input logic [15:0] k, input logic l, input logic [3:0] u);
    bit hs;
    int n;
    s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tuser = u; s_axis_tvalid = 1'b1;
    hs = 1'b0; n = 0;
    while (!hs && n < 300) begin
      @(negedge user_clk);
      hs = s_axis_tready;
      @(posedge user_clk); #1;
      n++;
    end
    if (!hs) chk("send_timeout", 160'd0, 160'd1);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] dst, input logic [3:0] ch, input logic [3:0] u, input int npl);
    send_beat(hdr_beat(dst, ch, 28'($urandom), {$urandom, 16'($urandom)}), 16'hFFFF, npl == 0, u);
    for (int p = 0; p < npl; p++)
      send_beat({$urandom, $urandom, $urandom, $urandom}, 16'($urandom), p == npl - 1, 4'($urandom));
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) @(posedge user_clk);
    #1;
  endtask

  task automatic checkpoint(input string tag);
    chk({tag, "_frame_cnt"}, frame_cnt, m_fcnt);
    chk({tag, "_drop_cnt"}, drop_cnt, m_dcnt);
    chk({tag, "_rx_dst"}, rx_dst_mac_addr, m_dst);
    chk({tag, "_rx_chan"}, rx_chan, m_chan);
    chk({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_tvalid"}, m_axis_tvalid, 0);
    chk({tag, "_tdata"}, m_axis_tdata, 0);
    chk({tag, "_tkeep_last_user"}, {m_axis_tkeep, m_axis_tlast, m_axis_tuser}, 0);
    chk({tag, "_rx_dst"}, rx_dst_mac_addr, 0);
    chk({tag, "_rx_chan"}, rx_chan, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
    chk({tag, "_drop_cnt"}, drop_cnt, 0);
  endtask

  // ---------------- directed cycle table ----------------
  typedef struct {
    logic v; logic hdr; logic [47:0] dst; logic [3:0] ch; logic [3:0] u; logic l;
    logic [31:0] pl; logic [3:0] mr; logic sr; logic [3:0] mv;
  } vec_t;

  function automatic vec_t H(input logic [47:0] dst, input logic [3:0] ch, input logic [3:0] u,
                             input logic l, input logic [3:0] mr, input logic sr, input logic [3:0] mv);
    return '{1'b1, 1'b1, dst, ch, u, l, 32'd0, mr, sr, mv};
  endfunction
  function automatic vec_t P(input logic [31:0] pl, input logic l, input logic [3:0] mr,
                             input logic sr, input logic [3:0] mv);
    return '{1'b1, 1'b0, 48'd0, 4'd0, 4'hA, l, pl, mr, sr, mv};
  endfunction
  function automatic vec_t I(input logic sr, input logic [3:0] mv);
    return '{1'b0, 1'b0, 48'd0, 4'd0, 4'd0, 1'b0, 32'd0, 4'hF, sr, mv};
  endfunction

  localparam int NV = 31;
  vec_t tbl[NV];

  initial begin
    // match ch2, 3 beats
    tbl[0]  = H(LMAC, 2, 0, 0, 4'hF, 1, 4'b0000);
    tbl[1]  = P(32'hA1, 0, 4'hF, 1, 4'b0000);
    tbl[2]  = P(32'hA2, 0, 4'hF, 1, 4'b0100);
    tbl[3]  = P(32'hA3, 1, 4'hF, 1, 4'b0100);
    tbl[4]  = I(1, 4'b0100);
    tbl[5]  = I(1, 4'b0000);
    // dst mismatch, 4 beats
    tbl[6]  = H(MMAC, 2, 0, 0, 4'hF, 1, 4'b0000);
    tbl[7]  = P(32'hD1, 0, 4'hF, 1, 4'b0000);
    tbl[8]  = P(32'hD2, 0, 4'hF, 1, 4'b0000);
    tbl[9]  = P(32'hD3, 1, 4'hF, 1, 4'b0000);
    // upstream error, out-of-range index, single-beat header
    tbl[10] = H(LMAC, 2, 4'b0100, 0, 4'hF, 1, 4'b0000);
    tbl[11] = P(32'hE1, 1, 4'hF, 1, 4'b0000);
    tbl[12] = H(LMAC, 5, 0, 0, 4'hF, 1, 4'b0000);
    tbl[13] = P(32'hE2, 1, 4'hF, 1, 4'b0000);
    tbl[14] = H(LMAC, 1, 0, 1, 4'hF, 1, 4'b0000);
    // ch1 with 5 cycles of backpressure
    tbl[15] = H(LMAC, 1, 4'b0001, 0, 4'hF, 1, 4'b0000);
    tbl[16] = P(32'hB1, 0, 4'hF, 1, 4'b0000);
    for (int i = 17; i < 22; i++) tbl[i] = P(32'hB2, 0, 4'hD, 0, 4'b0010);
    tbl[22] = P(32'hB2, 0, 4'hF, 1, 4'b0010);
    tbl[23] = P(32'hB3, 1, 4'hF, 1, 4'b0010);
    // back-to-back ch0 then ch3
    tbl[24] = H(LMAC, 0, 0, 0, 4'hF, 1, 4'b0010);
    tbl[25] = P(32'hC1, 0, 4'hF, 1, 4'b0000);
    tbl[26] = P(32'hC2, 1, 4'hF, 1, 4'b0001);
    tbl[27] = H(LMAC, 3, 0, 0, 4'hF, 1, 4'b0001);
    tbl[28] = P(32'hF1, 1, 4'hF, 1, 4'b0000);
    tbl[29] = I(1, 4'b1000);
    tbl[30] = I(1, 4'b0000);
  end

  initial begin
    reset_n = 1'b0;
    local_mac_addr = LMAC;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0; s_axis_tuser = '0;
    repeat (2) @(posedge user_clk);
    #1;
    check_reset_vals("reset");
    reset_n = 1'b1;
    @(negedge user_clk);
    chk("reset_sready", s_axis_tready, 1);

    for (int i = 0; i < NV; i++) begin
      @(posedge user_clk); #1;
      s_axis_tvalid = tbl[i].v;
      s_axis_tdata  = tbl[i].hdr ? hdr_beat(tbl[i].dst, tbl[i].ch, 28'h0, 48'h00AABBCCDDEE)
                                 : {4{tbl[i].pl}};
      s_axis_tkeep  = 16'hFFFF;
      s_axis_tlast  = tbl[i].l;
      s_axis_tuser  = tbl[i].u;
      tbl_ready     = tbl[i].mr;
      @(negedge user_clk);
      chk($sformatf("tbl%0d_sready", i), s_axis_tready, tbl[i].sr);
      chk($sformatf("tbl%0d_mvalid", i), m_axis_tvalid, tbl[i].mv);
    end
    @(posedge user_clk); #1;
    idle(2);
    chk("tbl_frame_cnt", frame_cnt, 4);
    chk("tbl_drop_cnt", drop_cnt, 4);
    chk("tbl_rx_chan", rx_chan, 3);
    chk("tbl_rx_dst", rx_dst_mac_addr, LMAC);
    checkpoint("tbl");

    // broadcast destination
    send_frame(BMAC, 1, 4'h0, 2);
    idle(4);
    chk("bcast_frame_cnt", frame_cnt, BCAST_OK ? 5 : 4);
    chk("bcast_drop_cnt", drop_cnt, BCAST_OK ? 4 : 5);
    checkpoint("bcast");

    // randomized frames with random per-channel ready
    rand_en = 1'b1;
    for (int f = 0; f < 80; f++) begin
      logic [47:0] dst;
      int r;
      r = $urandom_range(0, 7);
      dst = (r == 0) ? {$urandom, 16'($urandom)} : (r == 1) ? BMAC : LMAC;
      idle($urandom_range(0, 2));
      send_frame(dst, 4'($urandom_range(0, 5)),
                 {1'b0, ($urandom_range(0, 7) == 0), 2'($urandom)}, $urandom_range(0, 5));
    end
    rand_en = 1'b0;
    idle(6);
    checkpoint("rand");

    // reset while a beat is held in the output slot
    tbl_ready = 4'b0000;
    send_beat(hdr_beat(LMAC, 2, 28'h0, 48'h1), 16'hFFFF, 1'b0, 4'h3);
    send_beat({4{32'h5A5A0001}}, 16'hFFFF, 1'b0, 4'h0);
    s_axis_tdata = {4{32'h5A5A0002}}; s_axis_tvalid = 1'b1;
    @(negedge user_clk);
    chk("midrst_sready_pre", s_axis_tready, 0);
    chk("midrst_mvalid_pre", m_axis_tvalid, 4'b0100);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("midrst");
    s_axis_tvalid = 1'b0;
    tbl_ready = 4'hF;
    @(posedge user_clk); #1;
    reset_n = 1'b1;
    send_frame(LMAC, 3, 4'h0, 2);
    idle(4);
    chk("post_rst_frame_cnt", frame_cnt, 1);
    chk("post_rst_drop_cnt", drop_cnt, 0);
    checkpoint("post_rst");

    applied     = applied + mon_applied;
    miscompares = miscompares + mon_miss;
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
